// File: rtl/sipo_frame_controller.sv
// Frame-aware serial-receive sequencer: hunts an LSB-first stream for a sync byte, reads a length
// byte, then delivers payload bytes over valid/ready. Optional parity checking via SIPO_PARITY_EN.
module sipo_frame_controller #(
    parameter logic [7:0]  SYNC_PATTERN = 8'hA5,
    parameter int unsigned MAX_LEN      = 16
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       serialIn,
    input  logic       bitValid,
    input  logic       byteReady,
    input  logic       clearErrors,
    output logic [7:0] byteOut,
    output logic       byteValid,
    output logic       frameStart,
    output logic       frameEnd,
    output logic       lengthError,
    output logic       overrun,
`ifdef SIPO_PARITY_EN
    output logic       parityError,
`endif
    output logic [1:0] state
);

`ifdef SIPO_PARITY_EN
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned BYTE_LAST = 8;
`else
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned BYTE_LAST = 7;
`endif

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LENGTH  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t             st;
    logic [7:0]         sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic [7:0]         rem_cnt;

    logic [7:0]         sr_next;
    logic               len_last;
    logic               byte_done;
    logic               shift_en;
    logic [7:0]         done_byte;
    logic               len_bad;
    logic               can_load;

    assign state    = st;
    assign sr_next  = {serialIn, sr[7:1]};
    assign len_last = (bit_cnt == CNT_W'(7));
    assign len_bad  = (sr_next == 8'd0) || (32'(sr_next) > MAX_LEN);
    assign can_load = !byteValid || byteReady;

    // With parity the 9th bit completes the byte and must not enter the data window.
`ifdef SIPO_PARITY_EN
    logic parity_bad;
    assign byte_done  = (bit_cnt == CNT_W'(BYTE_LAST));
    assign shift_en   = !byte_done;
    assign done_byte  = sr;
    assign parity_bad = ^{sr, serialIn};
`else
    assign byte_done  = (bit_cnt == CNT_W'(BYTE_LAST));
    assign shift_en   = 1'b1;
    assign done_byte  = sr_next;
`endif

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            st          <= HUNT;
            sr          <= 8'd0;
            bit_cnt     <= '0;
            rem_cnt     <= 8'd0;
            byteOut     <= 8'd0;
            byteValid   <= 1'b0;
            frameStart  <= 1'b0;
            frameEnd    <= 1'b0;
            lengthError <= 1'b0;
            overrun     <= 1'b0;
`ifdef SIPO_PARITY_EN
            parityError <= 1'b0;
`endif
        end else begin
            frameStart <= 1'b0;
            frameEnd   <= 1'b0;

            if (byteValid && byteReady) begin
                byteValid <= 1'b0;
            end

            // Clear first so a coincident error event below keeps the flag set.
            if (clearErrors) begin
                lengthError <= 1'b0;
                overrun     <= 1'b0;
`ifdef SIPO_PARITY_EN
                parityError <= 1'b0;
`endif
            end

            if (bitValid) begin
                case (st)
                    HUNT: begin
                        sr <= sr_next;
                        if (sr_next == SYNC_PATTERN) begin
                            st         <= LENGTH;
                            frameStart <= 1'b1;
                            bit_cnt    <= '0;
                        end
                    end

                    LENGTH: begin
                        sr <= sr_next;
                        if (len_last) begin
                            bit_cnt <= '0;
                            if (len_bad) begin
                                lengthError <= 1'b1;
                                st          <= HUNT;
                            end else begin
                                rem_cnt <= sr_next;
                                st      <= PAYLOAD;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end

                    PAYLOAD: begin
                        if (shift_en) begin
                            sr <= sr_next;
                        end
                        if (byte_done) begin
                            bit_cnt <= '0;
                            rem_cnt <= rem_cnt - 8'd1;
                            if (can_load) begin
                                byteOut   <= done_byte;
                                byteValid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
`ifdef SIPO_PARITY_EN
                            if (parity_bad) begin
                                parityError <= 1'b1;
                            end
`endif
                            if (rem_cnt == 8'd1) begin
                                frameEnd <= 1'b1;
                                st       <= HUNT;
                                sr       <= 8'd0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end

                    default: begin
                        st      <= HUNT;
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Directed self-checking bench for sipo_frame_controller (default build, no parity).
`timescale 1ns/1ps
module tb_sipo_frame_controller;

    logic       clock;
    logic       resetN;
    logic       serialIn;
    logic       bitValid;
    logic       byteReady;
    logic       clearErrors;
    logic [7:0] byteOut;
    logic       byteValid;
    logic       frameStart;
    logic       frameEnd;
    logic       lengthError;
    logic       overrun;
`ifdef SIPO_PARITY_EN
    logic       parityError;
`endif
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    int fs_count = 0;
    int fe_count = 0;
    int bv_count = 0;
    int acc_n    = 0;
    logic [7:0] acc_mem [64];

    sipo_frame_controller #(.SYNC_PATTERN(8'hA5), .MAX_LEN(16)) dut (
        .clock       (clock),
        .resetN      (resetN),
        .serialIn    (serialIn),
        .bitValid    (bitValid),
        .byteReady   (byteReady),
        .clearErrors (clearErrors),
        .byteOut     (byteOut),
        .byteValid   (byteValid),
        .frameStart  (frameStart),
        .frameEnd    (frameEnd),
        .lengthError (lengthError),
        .overrun     (overrun),
`ifdef SIPO_PARITY_EN
        .parityError (parityError),
`endif
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse/handshake bookkeeping sampled mid-cycle.
    always @(negedge clock) begin
        if (resetN) begin
            if (frameStart) fs_count <= fs_count + 1;
            if (frameEnd)   fe_count <= fe_count + 1;
            if (byteValid)  bv_count <= bv_count + 1;
            if (byteValid && byteReady && acc_n < 64) begin
                acc_mem[acc_n] <= byteOut;
                acc_n          <= acc_n + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bitValid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_bit(input logic b);
        serialIn = b;
        bitValid = 1'b1;
        step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic do_reset();
        resetN      = 1'b0;
        serialIn    = 1'b0;
        bitValid    = 1'b0;
        byteReady   = 1'b0;
        clearErrors = 1'b0;
        step();
        step();
        resetN = 1'b1;
    endtask

    task automatic pulse_clear();
        clearErrors = 1'b1;
        idle(1);
        clearErrors = 1'b0;
    endtask

    int fs0, fe0, bv0, acc0;
    logic [7:0] junk;
    logic [7:0] sync_b;

    initial begin
        resetN = 1'b0;
        do_reset();

        // Reset state
        check("rst_state", 32'(state), 32'd0);
        check("rst_bv", 32'(byteValid), 32'd0);
        check("rst_out", 32'(byteOut), 32'd0);
        check("rst_flags", 32'({frameStart, frameEnd, lengthError, overrun}), 32'd0);

        // Basic frame: A5 02 3C C3
        byteReady = 1'b1;
        bv0 = bv_count; acc0 = acc_n;
        send_byte(8'hA5);
        check("basic_fs", 32'(frameStart), 32'd1);
        check("basic_len_state", 32'(state), 32'd1);
        send_byte(8'h02);
        check("basic_fs_gone", 32'(frameStart), 32'd0);
        check("basic_pay_state", 32'(state), 32'd2);
        send_byte(8'h3C);
        check("basic_b0_valid", 32'(byteValid), 32'd1);
        check("basic_b0", 32'(byteOut), 32'h3C);
        send_byte(8'hC3);
        check("basic_b1_valid", 32'(byteValid), 32'd1);
        check("basic_b1", 32'(byteOut), 32'hC3);
        check("basic_fe", 32'(frameEnd), 32'd1);
        check("basic_end_state", 32'(state), 32'd0);
        idle(1);
        check("basic_fe_gone", 32'(frameEnd), 32'd0);
        check("basic_bv_gone", 32'(byteValid), 32'd0);
        check("basic_bv_cycles", 32'(bv_count - bv0), 32'd2);
        check("basic_acc_n", 32'(acc_n - acc0), 32'd2);
        check("basic_acc0", 32'(acc_mem[acc0]), 32'h3C);
        check("basic_acc1", 32'(acc_mem[acc0 + 1]), 32'hC3);

        // Unaligned sync: junk 1,0,1 then A5
        do_reset();
        fs0 = fs_count;
        junk = 8'b0000_0101;
        sync_b = 8'hA5;
        for (int i = 0; i < 3; i++) send_bit(junk[i]);
        for (int i = 0; i < 7; i++) send_bit(sync_b[i]);
        idle(1);
        check("unal_no_early", 32'(fs_count - fs0), 32'd0);
        check("unal_hunt", 32'(state), 32'd0);
        send_bit(sync_b[7]);
        check("unal_fs", 32'(frameStart), 32'd1);
        check("unal_state", 32'(state), 32'd1);

        // 5A must not match
        do_reset();
        fs0 = fs_count;
        send_byte(8'h5A);
        idle(1);
        check("5a_no_fs", 32'(fs_count - fs0), 32'd0);
        check("5a_state", 32'(state), 32'd0);

        // Length error: 00
        do_reset();
        bv0 = bv_count;
        send_byte(8'hA5);
        send_byte(8'h00);
        check("len0_err", 32'(lengthError), 32'd1);
        check("len0_state", 32'(state), 32'd0);
        idle(1);
        check("len0_sticky", 32'(lengthError), 32'd1);
        check("len0_no_bv", 32'(bv_count - bv0), 32'd0);
        pulse_clear();
        check("len0_clear", 32'(lengthError), 32'd0);

        // Length error: MAX_LEN+1
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h11);
        check("len17_err", 32'(lengthError), 32'd1);
        check("len17_state", 32'(state), 32'd0);

        // Length exactly MAX_LEN is legal
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h10);
        check("len16_ok", 32'(lengthError), 32'd0);
        check("len16_state", 32'(state), 32'd2);

        // Backpressure: A5 02 11 22, byteReady low
        do_reset();
        fe0 = fe_count; acc0 = acc_n;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        check("bp_b0_valid", 32'(byteValid), 32'd1);
        check("bp_b0", 32'(byteOut), 32'h11);
        check("bp_no_ovr_yet", 32'(overrun), 32'd0);
        send_byte(8'h22);
        check("bp_ovr", 32'(overrun), 32'd1);
        check("bp_hold", 32'(byteOut), 32'h11);
        check("bp_fe", 32'(frameEnd), 32'd1);
        check("bp_state", 32'(state), 32'd0);
        pulse_clear();
        check("bp_ovr_clear", 32'(overrun), 32'd0);
        check("bp_still_valid", 32'(byteValid), 32'd1);
        check("bp_still_hold", 32'(byteOut), 32'h11);
        byteReady = 1'b1;
        idle(1);
        check("bp_accepted", 32'(byteValid), 32'd0);
        check("bp_acc_n", 32'(acc_n - acc0), 32'd1);
        check("bp_acc0", 32'(acc_mem[acc0]), 32'h11);
        check("bp_fe_count", 32'(fe_count - fe0), 32'd1);

        // Simultaneous accept/load on the 2nd byte's last bit
        do_reset();
        acc0 = acc_n;
        sync_b = 8'h99;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h66);
        check("sim_b0", 32'(byteOut), 32'h66);
        for (int i = 0; i < 7; i++) send_bit(sync_b[i]);
        check("sim_b0_hold", 32'(byteOut), 32'h66);
        byteReady = 1'b1;
        send_bit(sync_b[7]);
        check("sim_b1_valid", 32'(byteValid), 32'd1);
        check("sim_b1", 32'(byteOut), 32'h99);
        check("sim_no_ovr", 32'(overrun), 32'd0);
        check("sim_fe", 32'(frameEnd), 32'd1);
        idle(1);
        check("sim_drained", 32'(byteValid), 32'd0);
        check("sim_acc_n", 32'(acc_n - acc0), 32'd2);
        check("sim_acc1", 32'(acc_mem[acc0 + 1]), 32'h99);

        // Reset mid-payload
        do_reset();
        byteReady = 1'b1;
        sync_b = 8'hF0;
        send_byte(8'hA5);
        send_byte(8'h03);
        for (int i = 0; i < 4; i++) send_bit(sync_b[i]);
        fe0 = fe_count;
        bitValid = 1'b0;
        resetN = 1'b0;
        #1;
        check("mrst_state", 32'(state), 32'd0);
        check("mrst_outs", 32'({byteOut, byteValid, frameStart, frameEnd, lengthError, overrun}), 32'd0);
        step();
        resetN = 1'b1;
        idle(1);
        check("mrst_no_fe", 32'(fe_count - fe0), 32'd0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h7E);
        check("mrst_fresh_b", 32'(byteOut), 32'h7E);
        check("mrst_fresh_fe", 32'(frameEnd), 32'd1);
        idle(1);
        check("mrst_fe_count", 32'(fe_count - fe0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
